// File: rtl/led_send_mc.sv
// led_send_mc
// Multi-channel APA102-style LED sender. CH_NUM strips share one bit clock
// (cko_o) and each strip has its own data line (sdo[c]) fed from its own
// show-ahead RGB FIFO. A transaction sends WAIT_CNT idle bit periods, a
// 32-bit zero start frame, LED_NUM LED words per channel, END_WORDS words of
// all-ones end frame, then WAIT_CNT more idle bit periods.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   start        transaction request, only looked at in IDLE
//   brightness   5-bit global brightness, captured when start is accepted
//   fifo_data_in per-channel {B,G,R}, channel c at [24c+23:24c]
//   fifo_empty   per-channel FIFO empty
//   rd           per-channel one-cycle pop strobe
//   cko_o        shared LED bit clock
//   sdo          per-channel serial data, MSB first
//   busy         high while a transaction is in progress
//   done         one-cycle pulse as busy falls
//   underrun     sticky per-channel flag, FIFO was empty at an LED fetch
module led_send_mc #(
  parameter int CH_NUM   = 2,
  parameter int LED_NUM  = 4,
  parameter int DIV_CNT  = 5,
  parameter int WAIT_CNT = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4:0]           brightness,
  input  logic [24*CH_NUM-1:0] fifo_data_in,
  input  logic [CH_NUM-1:0]    fifo_empty,
  output logic [CH_NUM-1:0]    rd,
  output logic                 cko_o,
  output logic [CH_NUM-1:0]    sdo,
  output logic                 busy,
  output logic                 done,
  output logic [CH_NUM-1:0]    underrun
);

  localparam int END_WORDS = (LED_NUM <= 64) ? 1 : (LED_NUM + 63) / 64;
  localparam int PH_W      = $clog2(2 * DIV_CNT);
  localparam int LED_W     = $clog2(LED_NUM + 1);
  localparam int END_W     = $clog2(END_WORDS + 1);
  localparam int WAIT_W    = $clog2(WAIT_CNT + 1);

  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(2 * DIV_CNT - 1);
  localparam logic [PH_W-1:0]   PH_HIGH   = PH_W'(DIV_CNT);
  localparam logic [LED_W-1:0]  LED_LAST  = LED_W'(LED_NUM - 1);
  localparam logic [END_W-1:0]  END_LAST  = END_W'(END_WORDS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CNT - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRE_WAIT,
    START_FR,
    LED_FR,
    END_FR,
    POST_WAIT
  } state_t;

  state_t                   state_q, state_d;
  logic [PH_W-1:0]          ph_q, ph_d;
  logic [4:0]               bit_q, bit_d;
  logic [LED_W-1:0]         led_q, led_d;
  logic [END_W-1:0]         end_q, end_d;
  logic [WAIT_W-1:0]        wait_q, wait_d;
  logic [4:0]               bright_q, bright_d;
  logic [CH_NUM-1:0][31:0]  shift_q, shift_d;
  logic [CH_NUM-1:0]        underrun_q, underrun_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     cko_q, cko_d;
  logic                     bit_end;
  logic                     fetch;

  // Next-state logic. A bit period ends on ph = 2*DIV_CNT-1; all state and
  // word changes happen on that cycle, so sdo only moves as ph wraps to 0,
  // well away from the cko_o rising edge at ph = DIV_CNT.
  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    bit_d      = bit_q;
    led_d      = led_q;
    end_d      = end_q;
    wait_d     = wait_q;
    bright_d   = bright_q;
    shift_d    = shift_q;
    underrun_d = underrun_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    fetch      = 1'b0;
    bit_end    = (ph_q == PH_LAST);

    if (state_q != IDLE) begin
      ph_d = bit_end ? '0 : ph_q + PH_W'(1);
    end

    case (state_q)
      IDLE: begin
        ph_d = '0;
        if (start) begin
          state_d    = PRE_WAIT;
          bright_d   = brightness;
          underrun_d = '0;
          busy_d     = 1'b1;
          wait_d     = '0;
          bit_d      = '0;
        end
      end
      PRE_WAIT: begin
        if (bit_end) begin
          if (wait_q == WAIT_LAST) begin
            state_d = START_FR;
            wait_d  = '0;
            bit_d   = '0;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end
      START_FR: begin
        if (bit_end) begin
          bit_d = bit_q + 5'd1;
          if (bit_q == 5'd31) begin
            state_d = LED_FR;
            led_d   = '0;
            fetch   = 1'b1;
          end
        end
      end
      LED_FR: begin
        if (bit_end) begin
          bit_d = bit_q + 5'd1;
          if (bit_q == 5'd31) begin
            if (led_q == LED_LAST) begin
              state_d = END_FR;
              end_d   = '0;
            end else begin
              led_d = led_q + LED_W'(1);
              fetch = 1'b1;
            end
          end
        end
      end
      END_FR: begin
        if (bit_end) begin
          bit_d = bit_q + 5'd1;
          if (bit_q == 5'd31) begin
            if (end_q == END_LAST) begin
              state_d = POST_WAIT;
              wait_d  = '0;
            end else begin
              end_d = end_q + END_W'(1);
            end
          end
        end
      end
      POST_WAIT: begin
        if (bit_end) begin
          if (wait_q == WAIT_LAST) begin
            state_d = IDLE;
            wait_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Shift registers: a fetch loads the next LED word (or a dark LED on an
    // empty FIFO); entering the end frame loads all ones; any other state
    // change clears the register so idle periods drive sdo low.
    for (int c = 0; c < CH_NUM; c++) begin
      if (fetch) begin
        if (fifo_empty[c]) begin
          shift_d[c]    = 32'hE000_0000;
          underrun_d[c] = 1'b1;
        end else begin
          shift_d[c] = {3'b111, bright_q, fifo_data_in[24*c +: 24]};
        end
      end else if (bit_end) begin
        if ((state_d == END_FR) && (state_q != END_FR)) begin
          shift_d[c] = '1;
        end else if (state_d != state_q) begin
          shift_d[c] = '0;
        end else begin
          shift_d[c] = {shift_q[c][30:0], state_q == END_FR};
        end
      end
    end

    cko_d = ((state_d == START_FR) || (state_d == LED_FR) || (state_d == END_FR)) &&
            (ph_d >= PH_HIGH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ph_q       <= '0;
      bit_q      <= '0;
      led_q      <= '0;
      end_q      <= '0;
      wait_q     <= '0;
      bright_q   <= '0;
      shift_q    <= '0;
      underrun_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cko_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      bit_q      <= bit_d;
      led_q      <= led_d;
      end_q      <= end_d;
      wait_q     <= wait_d;
      bright_q   <= bright_d;
      shift_q    <= shift_d;
      underrun_q <= underrun_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cko_q      <= cko_d;
    end
  end

  // The pop strobe coincides with the edge that loads the shift register,
  // so a show-ahead FIFO advances exactly when its head word is consumed.
  assign rd = {CH_NUM{fetch}} & ~fifo_empty;

  always_comb begin
    sdo = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      sdo[c] = shift_q[c][31];
    end
  end

  assign cko_o    = cko_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_led_send_mc.sv
// Testbench for led_send_mc: a default two-channel instance with FIFO models
// and a long single-channel instance (LED_NUM=100, DIV_CNT=2) for the
// multi-word end frame.
module tb_led_send_mc;

   logic        clk;
   logic        rst;
   logic        start;
   logic [4:0]  brightness;
   logic [47:0] fifoDataIn;
   logic [1:0]  fifoEmpty;
   logic [1:0]  rd;
   logic        cko_o;
   logic [1:0]  sdo;
   logic        busy;
   logic        done;
   logic [1:0]  underrun;

   logic        startL;
   logic        rdL;
   logic        ckoL;
   logic        sdoL;
   logic        busyL;
   logic        doneL;
   logic        underrunL;

   int checks = 0;
   int errors = 0;

   logic [23:0] mem [2][16];
   int          wp [2];
   int          rp [2];
   int          rdCount [2];
   logic        clr;

   logic        capBits [2][512];
   int          capCount [2];
   int          sinceChange [2];
   int          stabBad;
   int          rdBad;
   logic        ckoPrev;
   logic [1:0]  sdoPrev;
   logic [1:0]  rdPrev;

   int          risesL;
   int          onesL;
   int          rdCountL;
   logic        ckoPrevL;

   int          busyCycles;
   int          donePulses;
   int          doneCycle;
   int          doneWithBusy;
   int          ckoWaitHigh;
   int          firstRdCycle;
   logic [1:0]  urCycle1;
   logic [1:0]  urBefore;
   logic [8:0]  rstSnap;

   led_send_mc #(.CH_NUM(2), .LED_NUM(4), .DIV_CNT(5), .WAIT_CNT(5)) dut (
      .clk(clk), .rst(rst), .start(start), .brightness(brightness),
      .fifo_data_in(fifoDataIn), .fifo_empty(fifoEmpty), .rd(rd),
      .cko_o(cko_o), .sdo(sdo), .busy(busy), .done(done), .underrun(underrun)
   );

   led_send_mc #(.CH_NUM(1), .LED_NUM(100), .DIV_CNT(2), .WAIT_CNT(5)) dutLong (
      .clk(clk), .rst(rst), .start(startL), .brightness(5'h1F),
      .fifo_data_in(24'h123450), .fifo_empty(1'b0), .rd(rdL),
      .cko_o(ckoL), .sdo(sdoL), .busy(busyL), .done(doneL), .underrun(underrunL)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Show-ahead FIFO models: head word and empty flag follow the read pointer.
   assign fifoEmpty[0] = (rp[0] >= wp[0]);
   assign fifoEmpty[1] = (rp[1] >= wp[1]);
   assign fifoDataIn[23:0]  = mem[0][rp[0][3:0]];
   assign fifoDataIn[47:24] = mem[1][rp[1][3:0]];

   // Pops and pop counts, cleared by clr before each scenario.
   always @(posedge clk) begin
      for (int c = 0; c < 2; c++) begin
         if (clr) begin
            rp[c] <= 0;
            rdCount[c] <= 0;
         end else if (rd[c]) begin
            rdCount[c] <= rdCount[c] + 1;
            if (rp[c] < wp[c]) rp[c] <= rp[c] + 1;
         end
      end
   end

   // Capture sdo at every cko_o rise, check sdo has been quiet for the
   // preceding DIV_CNT cycles, and check rd lands on the last cycle of a bit
   // (cko_o high now, low on the following cycle).
   always @(negedge clk) begin
      if (clr) begin
         for (int c = 0; c < 2; c++) begin
            capCount[c] <= 0;
            sinceChange[c] <= 100;
         end
         stabBad <= 0;
         rdBad <= 0;
      end else begin
         for (int c = 0; c < 2; c++) begin
            if (cko_o && !ckoPrev) begin
               if (capCount[c] < 512) capBits[c][capCount[c]] <= sdo[c];
               capCount[c] <= capCount[c] + 1;
               if ((sdo[c] != sdoPrev[c]) || (sinceChange[c] < 4)) stabBad <= stabBad + 1;
            end
            sinceChange[c] <= (sdo[c] != sdoPrev[c]) ? 0 : sinceChange[c] + 1;
         end
         if ((rd != 2'b00) && !cko_o) rdBad <= rdBad + 1;
         if ((rdPrev != 2'b00) && cko_o) rdBad <= rdBad + 1;
      end
      ckoPrev <= cko_o;
      sdoPrev <= sdo;
      rdPrev <= rd;
   end

   // Long-instance monitor: bit count, trailing ones run, pop count.
   always @(negedge clk) begin
      if (clr) begin
         risesL <= 0;
         onesL <= 0;
         rdCountL <= 0;
      end else begin
         if (ckoL && !ckoPrevL) begin
            risesL <= risesL + 1;
            onesL <= sdoL ? onesL + 1 : 0;
         end
         if (rdL) rdCountL <= rdCountL + 1;
      end
      ckoPrevL <= ckoL;
   end

   function automatic logic [23:0] fifoVal(input int c, input int i);
      logic [23:0] base;
      base = (c == 0) ? 24'h112233 : 24'hAABBCC;
      return base + 24'(i) * 24'h111111;
   endfunction

   function automatic logic [31:0] capWord(input int c, input int w);
      logic [31:0] r;
      for (int b = 0; b < 32; b++) r[31-b] = capBits[c][32*w+b];
      return r;
   endfunction

   task automatic clearMon();
      @(posedge clk);
      #1;
      clr = 1'b1;
      wp[0] = 0;
      wp[1] = 0;
      @(posedge clk);
      #1;
      clr = 1'b0;
   endtask

   task automatic loadFifo(input int c, input int n);
      for (int i = 0; i < n; i++) mem[c][i] = fifoVal(c, i);
      wp[c] = n;
   endtask

   // Runs one transaction on the default instance. Cycle 1 is the cycle right
   // after the accepting edge; busy is expected in cycles 1..2020 and done in
   // cycle 2021, i.e. done rises on the 2020th edge after acceptance as busy
   // falls. Optionally re-asserts start / changes brightness mid-run, or
   // applies reset at a given cycle.
   task automatic runTxn(input logic [4:0] br, input int rstAt, input bit midChange);
      int cyc;
      busyCycles = 0;
      donePulses = 0;
      doneCycle = -1;
      doneWithBusy = 0;
      ckoWaitHigh = 0;
      firstRdCycle = -1;
      urCycle1 = 2'b11;
      urBefore = 2'b00;
      rstSnap = '1;
      @(posedge clk);
      #1;
      brightness = br;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc = 0;
      while (cyc < 2200) begin
         @(negedge clk);
         cyc++;
         if (busy) busyCycles++;
         if (done) begin
            donePulses++;
            if (busy) doneWithBusy++;
            if (doneCycle < 0) doneCycle = cyc;
         end
         if (cko_o && ((cyc <= 50) || ((cyc >= 1971) && (cyc <= 2020)))) ckoWaitHigh++;
         if ((rd != 2'b00) && (firstRdCycle < 0)) firstRdCycle = cyc;
         if (cyc == 1) urCycle1 = underrun;
         if (midChange && (cyc == 300)) begin
            start = 1'b1;
            brightness = 5'h03;
         end
         if (midChange && (cyc == 320)) start = 1'b0;
         if ((rstAt > 0) && (cyc == rstAt)) begin
            urBefore = underrun;
            rst = 1'b1;
         end
         if ((rstAt > 0) && (cyc == rstAt + 1)) begin
            rstSnap = {rd, cko_o, sdo, busy, done, underrun};
            rst = 1'b0;
            break;
         end
         if ((doneCycle > 0) && (cyc >= doneCycle + 5)) break;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (rd !== 2'b00) begin errors++; $display("[TB] FAIL reset_rd: got %b expected 00", rd); end
      checks++; if (cko_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_cko: got %b expected 0", cko_o); end
      checks++; if (sdo !== 2'b00) begin errors++; $display("[TB] FAIL reset_sdo: got %b expected 00", sdo); end
      checks++; if ({busy, done} !== 2'b00) begin errors++; $display("[TB] FAIL reset_busy_done: got %b expected 00", {busy, done}); end
      checks++; if (underrun !== 2'b00) begin errors++; $display("[TB] FAIL reset_underrun: got %b expected 00", underrun); end
      checks++; if ({rdL, ckoL, sdoL, busyL, doneL} !== 5'b0) begin errors++; $display("[TB] FAIL reset_long: got %b expected 00000", {rdL, ckoL, sdoL, busyL, doneL}); end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [31:0] exp;
      logic [31:0] got;
      clearMon();
      loadFifo(0, 4);
      loadFifo(1, 4);
      runTxn(5'h1F, 0, 1'b0);
      checks++; if (busyCycles !== 2020) begin errors++; $display("[TB] FAIL basic_busy_len: got %0d expected 2020", busyCycles); end
      checks++; if (donePulses !== 1) begin errors++; $display("[TB] FAIL basic_done_pulses: got %0d expected 1", donePulses); end
      checks++; if (doneCycle !== 2021) begin errors++; $display("[TB] FAIL basic_done_cycle: got %0d expected 2021", doneCycle); end
      checks++; if (doneWithBusy !== 0) begin errors++; $display("[TB] FAIL basic_done_with_busy: got %0d expected 0", doneWithBusy); end
      checks++; if (ckoWaitHigh !== 0) begin errors++; $display("[TB] FAIL basic_cko_in_wait: got %0d expected 0", ckoWaitHigh); end
      checks++; if (firstRdCycle !== 370) begin errors++; $display("[TB] FAIL basic_first_rd: got %0d expected 370", firstRdCycle); end
      checks++; if ((rdCount[0] !== 4) || (rdCount[1] !== 4)) begin errors++; $display("[TB] FAIL basic_rd_count: got %0d/%0d expected 4/4", rdCount[0], rdCount[1]); end
      checks++; if ((capCount[0] !== 192) || (capCount[1] !== 192)) begin errors++; $display("[TB] FAIL basic_bit_count: got %0d/%0d expected 192/192", capCount[0], capCount[1]); end
      checks++; if (stabBad !== 0) begin errors++; $display("[TB] FAIL basic_sdo_stable: got %0d violations expected 0", stabBad); end
      checks++; if (rdBad !== 0) begin errors++; $display("[TB] FAIL basic_rd_position: got %0d violations expected 0", rdBad); end
      checks++; if (underrun !== 2'b00) begin errors++; $display("[TB] FAIL basic_underrun: got %b expected 00", underrun); end
      for (int c = 0; c < 2; c++) begin
         for (int w = 0; w < 6; w++) begin
            if (w == 0) exp = 32'h0000_0000;
            else if (w == 5) exp = 32'hFFFF_FFFF;
            else exp = {8'hFF, fifoVal(c, w - 1)};
            got = capWord(c, w);
            checks++; if (got !== exp) begin errors++; $display("[TB] FAIL basic_word ch%0d w%0d: got %h expected %h", c, w, got, exp); end
         end
      end
   endtask

   task automatic test_underrun();
      logic [31:0] exp;
      logic [31:0] got;
      clearMon();
      loadFifo(0, 4);
      loadFifo(1, 2);
      runTxn(5'h1F, 0, 1'b0);
      checks++; if (underrun !== 2'b10) begin errors++; $display("[TB] FAIL underrun_flag: got %b expected 10", underrun); end
      checks++; if ((rdCount[0] !== 4) || (rdCount[1] !== 2)) begin errors++; $display("[TB] FAIL underrun_rd_count: got %0d/%0d expected 4/2", rdCount[0], rdCount[1]); end
      checks++; if (busyCycles !== 2020) begin errors++; $display("[TB] FAIL underrun_busy_len: got %0d expected 2020", busyCycles); end
      for (int c = 0; c < 2; c++) begin
         for (int w = 1; w < 5; w++) begin
            if ((c == 1) && (w >= 3)) exp = 32'hE000_0000;
            else exp = {8'hFF, fifoVal(c, w - 1)};
            got = capWord(c, w);
            checks++; if (got !== exp) begin errors++; $display("[TB] FAIL underrun_word ch%0d w%0d: got %h expected %h", c, w, got, exp); end
         end
      end
   endtask

   task automatic test_underrun_clear();
      clearMon();
      checks++; if (underrun !== 2'b10) begin errors++; $display("[TB] FAIL underrun_sticky: got %b expected 10", underrun); end
      loadFifo(0, 4);
      loadFifo(1, 4);
      runTxn(5'h1F, 0, 1'b0);
      checks++; if (urCycle1 !== 2'b00) begin errors++; $display("[TB] FAIL underrun_cleared_on_start: got %b expected 00", urCycle1); end
      checks++; if (underrun !== 2'b00) begin errors++; $display("[TB] FAIL underrun_after_clean: got %b expected 00", underrun); end
      checks++; if (capWord(1, 4) !== {8'hFF, fifoVal(1, 3)}) begin errors++; $display("[TB] FAIL underrun_clean_word: got %h expected %h", capWord(1, 4), {8'hFF, fifoVal(1, 3)}); end
   endtask

   task automatic test_ignore_start();
      logic [31:0] exp;
      logic [31:0] got;
      clearMon();
      loadFifo(0, 4);
      loadFifo(1, 4);
      runTxn(5'h1F, 0, 1'b1);
      checks++; if (busyCycles !== 2020) begin errors++; $display("[TB] FAIL ignore_busy_len: got %0d expected 2020", busyCycles); end
      checks++; if (donePulses !== 1) begin errors++; $display("[TB] FAIL ignore_done_pulses: got %0d expected 1", donePulses); end
      checks++; if (doneCycle !== 2021) begin errors++; $display("[TB] FAIL ignore_done_cycle: got %0d expected 2021", doneCycle); end
      for (int c = 0; c < 2; c++) begin
         for (int w = 1; w < 5; w++) begin
            exp = {8'hFF, fifoVal(c, w - 1)};
            got = capWord(c, w);
            checks++; if (got !== exp) begin errors++; $display("[TB] FAIL ignore_word ch%0d w%0d: got %h expected %h", c, w, got, exp); end
         end
      end
   endtask

   task automatic test_reset_mid();
      clearMon();
      loadFifo(0, 4);
      loadFifo(1, 1);
      runTxn(5'h1F, 1100, 1'b0);
      checks++; if (urBefore !== 2'b10) begin errors++; $display("[TB] FAIL midreset_underrun_before: got %b expected 10", urBefore); end
      checks++; if (rstSnap !== 9'b0) begin errors++; $display("[TB] FAIL midreset_outputs: got %b expected 000000000", rstSnap); end
      checks++; if (doneCycle !== -1) begin errors++; $display("[TB] FAIL midreset_no_done: got %0d expected -1", doneCycle); end
      repeat (3) @(negedge clk);
      checks++; if ({busy, cko_o, sdo} !== 4'b0) begin errors++; $display("[TB] FAIL midreset_stays_idle: got %b expected 0000", {busy, cko_o, sdo}); end
   endtask

   task automatic test_after_reset();
      logic [31:0] exp;
      logic [31:0] got;
      clearMon();
      loadFifo(0, 4);
      loadFifo(1, 4);
      runTxn(5'h1F, 0, 1'b0);
      checks++; if (busyCycles !== 2020) begin errors++; $display("[TB] FAIL afterreset_busy_len: got %0d expected 2020", busyCycles); end
      checks++; if ((capCount[0] !== 192) || (capCount[1] !== 192)) begin errors++; $display("[TB] FAIL afterreset_bit_count: got %0d/%0d expected 192/192", capCount[0], capCount[1]); end
      for (int c = 0; c < 2; c++) begin
         for (int w = 0; w < 6; w++) begin
            if (w == 0) exp = 32'h0000_0000;
            else if (w == 5) exp = 32'hFFFF_FFFF;
            else exp = {8'hFF, fifoVal(c, w - 1)};
            got = capWord(c, w);
            checks++; if (got !== exp) begin errors++; $display("[TB] FAIL afterreset_word ch%0d w%0d: got %h expected %h", c, w, got, exp); end
         end
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      int d1;
      int d2;
      int busy2;
      logic busyAfter;
      logic [31:0] exp;
      logic [31:0] got;
      clearMon();
      loadFifo(0, 8);
      loadFifo(1, 8);
      @(posedge clk);
      #1;
      brightness = 5'h1F;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc = 0;
      d1 = -1;
      d2 = -1;
      busy2 = 0;
      busyAfter = 1'b0;
      while (cyc < 4500) begin
         @(negedge clk);
         cyc++;
         if (done && (d1 < 0)) begin
            d1 = cyc;
            start = 1'b1;
         end else if ((d1 > 0) && (cyc == d1 + 1)) begin
            start = 1'b0;
            busyAfter = busy;
         end
         if ((d1 > 0) && (cyc > d1) && busy) busy2++;
         if (done && (d1 > 0) && (cyc > d1)) begin
            d2 = cyc;
            break;
         end
      end
      checks++; if (d1 !== 2021) begin errors++; $display("[TB] FAIL b2b_first_done: got %0d expected 2021", d1); end
      checks++; if (busyAfter !== 1'b1) begin errors++; $display("[TB] FAIL b2b_restart_busy: got %b expected 1", busyAfter); end
      checks++; if (busy2 !== 2020) begin errors++; $display("[TB] FAIL b2b_second_busy_len: got %0d expected 2020", busy2); end
      checks++; if (d2 - d1 !== 2021) begin errors++; $display("[TB] FAIL b2b_done_spacing: got %0d expected 2021", d2 - d1); end
      checks++; if ((rdCount[0] !== 8) || (rdCount[1] !== 8)) begin errors++; $display("[TB] FAIL b2b_rd_count: got %0d/%0d expected 8/8", rdCount[0], rdCount[1]); end
      for (int c = 0; c < 2; c++) begin
         for (int w = 7; w < 11; w++) begin
            exp = {8'hFF, fifoVal(c, w - 3)};
            got = capWord(c, w);
            checks++; if (got !== exp) begin errors++; $display("[TB] FAIL b2b_word ch%0d w%0d: got %h expected %h", c, w, got, exp); end
         end
      end
   endtask

   // LED_NUM=100, DIV_CNT=2: END_WORDS=2, T = 4*(10+32*103) = 13224.
   task automatic test_long();
      int cyc;
      int busyCnt;
      int doneAt;
      clearMon();
      @(posedge clk);
      #1;
      startL = 1'b1;
      @(posedge clk);
      #1;
      startL = 1'b0;
      cyc = 0;
      busyCnt = 0;
      doneAt = -1;
      while (cyc < 14000) begin
         @(negedge clk);
         cyc++;
         if (busyL) busyCnt++;
         if (doneL && (doneAt < 0)) doneAt = cyc;
         if ((doneAt > 0) && (cyc >= doneAt + 3)) break;
      end
      checks++; if (busyCnt !== 13224) begin errors++; $display("[TB] FAIL long_busy_len: got %0d expected 13224", busyCnt); end
      checks++; if (doneAt !== 13225) begin errors++; $display("[TB] FAIL long_done_cycle: got %0d expected 13225", doneAt); end
      checks++; if (risesL !== 3296) begin errors++; $display("[TB] FAIL long_bit_count: got %0d expected 3296", risesL); end
      checks++; if (onesL !== 64) begin errors++; $display("[TB] FAIL long_trailing_ones: got %0d expected 64", onesL); end
      checks++; if (rdCountL !== 100) begin errors++; $display("[TB] FAIL long_rd_count: got %0d expected 100", rdCountL); end
      checks++; if (underrunL !== 1'b0) begin errors++; $display("[TB] FAIL long_underrun: got %b expected 0", underrunL); end
   endtask

   // Scenario sequence.
   initial begin
      rst = 1'b1;
      start = 1'b0;
      startL = 1'b0;
      brightness = 5'h00;
      clr = 1'b0;
      wp[0] = 0;
      wp[1] = 0;
      test_reset();
      test_basic();
      test_underrun();
      test_underrun_clear();
      test_ignore_start();
      test_reset_mid();
      test_after_reset();
      test_back_to_back();
      test_long();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_send_mc.md
Name: led_send_mc

Overview:
- Multi-channel successor to the single-strip APA102-style LED sender.
- Drives CH_NUM LED strips in lockstep from one shared bit clock and one per-channel serial data line.
- Each strip is fed by its own show-ahead RGB FIFO.
- Adds a runtime global brightness, a configurable end-frame length, FIFO underrun handling, and busy/done status.

Parameters:
- CH_NUM, 2, number of strips / sdo lines (1..8).
- LED_NUM, 4, LED frames per strip per transaction (1..1024).
- DIV_CNT, 5, half bit period in clk cycles (>=2); bit period is 2*DIV_CNT.
- WAIT_CNT, 5, idle bit periods before the start frame and after the end frame (>=1).
- END_WORDS (localparam), max(1, ceil(LED_NUM/64)), number of 32-bit all-ones end-frame words.

Ports:
- clk  in  1  system clock (150 MHz).
- rst  in  1  synchronous, active-high reset.
- start  in  1  transaction request; sampled only in IDLE.
- brightness  in  5  global brightness; latched when start is accepted.
- fifo_data_in  in  24*CH_NUM  per-channel {B,G,R}; channel c occupies [24c+23:24c]; show-ahead (valid while !fifo_empty).
- fifo_empty  in  CH_NUM  per-channel FIFO empty.
- rd  out  CH_NUM  per-channel pop strobe, 1 cycle.
- cko_o  out  1  shared LED bit clock.
- sdo  out  CH_NUM  per-channel serial data, MSB first.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at transaction end.
- underrun  out  CH_NUM  sticky per-channel flag: FIFO was empty at an LED fetch.

Behaviour:
- Reset values: rd=0, cko_o=0, sdo=0, busy=0, done=0, underrun=0; state=IDLE; all counters 0.
- Reset applies from any state, including mid-transaction. There is no partial resume.
- States: IDLE -> PRE_WAIT -> START_FR -> LED_FR -> END_FR -> POST_WAIT -> IDLE.
- Bit timing: phase counter ph runs 0..2*DIV_CNT-1 in every non-IDLE state and is held at 0 in IDLE.
  - A bit period ends when ph = 2*DIV_CNT-1.
  - sdo updates on the cycle ph wraps to 0.
  - cko_o = (ph >= DIV_CNT) in START_FR, LED_FR and END_FR; cko_o = 0 otherwise.
  - sdo is therefore stable across every rising edge of cko_o.
- IDLE: when start=1 at a clock edge, the block latches brightness, clears underrun and enters PRE_WAIT.
- start while busy is ignored; it is not queued.
- PRE_WAIT: lasts WAIT_CNT bit periods with cko_o=0 and sdo=0.
- START_FR: 32 bits of 0 on every channel.
- LED_FR: LED_NUM words per channel. Each word is {3'b111, brightness_latched, fifo_data_in[ch]}.
  - Fetch strobe: last cycle of the preceding word (bit 31, ph = 2*DIV_CNT-1).
  - At the fetch strobe, each channel's shift register loads from its FIFO. rd[c] = fetch & !fifo_empty[c].
  - If fifo_empty[c]=1 at fetch: channel c loads 32'hE000_0000 (dark LED), rd[c] stays 0, underrun[c] is set.
  - Other channels are unaffected.
  - No fetch occurs for start-frame or end-frame words.
  - Exactly LED_NUM pops per channel per transaction when no underrun occurs.
- END_FR: 32*END_WORDS bits of 1 on every channel.
- POST_WAIT: lasts WAIT_CNT bit periods with cko_o=0 and sdo=0.
  - At the end of POST_WAIT, done pulses for 1 cycle concurrent with busy falling; next state is IDLE.
- Transaction length: T = 2*DIV_CNT*(2*WAIT_CNT + 32*(1+LED_NUM+END_WORDS)) clk cycles.
  - busy is high for T cycles.
  - done is high on the T-th cycle after the accepting edge.
  - Defaults give T = 2020.
- Back-to-back: start high in the cycle after done begins a new transaction with no gap beyond the IDLE cycle.
- Counter widths are sized from parameters with no wrap inside a transaction. The bit counter is 5 bits; the LED counter is clog2(LED_NUM+1) bits.

Test Plan:
- Defaults; FIFOs preloaded ch0 = 0x112233..0x445566, ch1 = 0xAABBCC..; brightness=5'h1F; start pulse -> busy high 2020 cycles, done one pulse; each sdo carries 32 zeros, then 0xFF112233 etc. (ch1 0xFFAABBCC...), then 32 ones; 4 rd pulses per channel, each at a bit-31 boundary.
- Sample sdo on cko_o rising edges -> exactly 192 data bits per channel; sdo never changes within DIV_CNT cycles before a rising edge; cko_o low in PRE_WAIT and POST_WAIT (50 cycles each per bit period x5).
- ch1 FIFO holds 2 entries, ch0 holds 4 -> ch1 words 3 and 4 = 0xE0000000, underrun = 2'b10, rd[1] pulses twice, ch0 normal; next start clears underrun.
- start asserted again during busy -> ignored; brightness changed mid-transaction to 5'h03 -> frame headers stay 0xFF (latched value).
- rst=1 during LED_FR word 2 -> next cycle all outputs 0 and state IDLE; a fresh start afterwards produces a full correct transaction.
- LED_NUM=100, DIV_CNT=2 -> END_WORDS=2, 64 trailing ones, T = 4*(10+32*103) = 13224 cycles.
